// File: rtl/knn_host_cmd.sv
// knn_host_cmd -- host command bridge onto a simple register bus.
//
// Accepts write/read commands on a valid/ready port and replays each one as a
// single-cycle strobe on the register bus, one cycle after acceptance.
// Read data comes back RD_LAT cycles after rd_en. It is captured together
// with its address into a response FIFO, which is drained over a valid/ready
// response port.
//
// Handshake rule for both cmd_* and rsp_*: a transfer happens on a rising
// clk edge where valid and ready are both high. Once valid is high it stays
// high, with its payload stable, until that transfer takes place.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   cmd_valid/ready/write/addr/wdata   command input
//   wr_en/wr_addr/wr_data    register-bus write strobe and payload
//   rd_en/rd_addr/rd_data    register-bus read strobe, address, return data
//   rsp_valid/ready/addr/data          read response output (issue order)
//   busy                     a read is in flight or a response is queued
//   wr_count/rd_count        issued strobe counters, saturating; these exist
//                            only when the KNN_HOST_CMD_STATS_EN macro is
//                            defined
//
// Flow control: a credit counter starts at RSP_DEPTH. Each accepted read
// takes one credit and each response pop returns one. When no credits are
// left, all commands stall, writes included, so that reads and writes stay in
// strict order.
module knn_host_cmd #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy
`ifdef KNN_HOST_CMD_STATS_EN
    ,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count
`endif
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = $clog2(RSP_DEPTH);

    logic              r_rdy_en;
    logic [CW-1:0]     r_credits;
    logic              r_wr_en;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [RD_LAT-1:0] r_pipe_v;
    logic [ADDR_W-1:0] r_pipe_a [RD_LAT];
    logic [ADDR_W+DATA_W-1:0] r_mem [RSP_DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;

    logic w_accept;
    logic w_acc_rd;
    logic w_acc_wr;
    logic w_push;
    logic w_pop;

    // r_rdy_en holds cmd_ready low until the first edge after reset release.
    assign cmd_ready = r_rdy_en && (r_credits != '0);
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_acc_rd  = w_accept && !cmd_write;
    assign w_acc_wr  = w_accept && cmd_write;
    // The last pipeline stage lines up with rd_data being valid.
    assign w_push    = r_pipe_v[RD_LAT-1];
    assign w_pop     = rsp_valid && rsp_ready;

    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign rd_en     = r_rd_en;
    assign rd_addr   = r_rd_addr;
    assign rsp_valid = (r_count != '0);
    assign {rsp_addr, rsp_data} = r_mem[r_rptr];
    assign busy      = r_rd_en || (|r_pipe_v) || (r_count != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdy_en  <= 1'b0;
            r_credits <= CW'(RSP_DEPTH);
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_rd_addr <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            r_wr_en  <= w_acc_wr;
            r_rd_en  <= w_acc_rd;
            if (w_acc_wr) begin
                r_wr_addr <= cmd_addr;
                r_wr_data <= cmd_wdata;
            end
            if (w_acc_rd) begin
                r_rd_addr <= cmd_addr;
            end
            // A read taken and a pop in the same cycle cancel out.
            if (w_acc_rd && !w_pop) begin
                r_credits <= r_credits - 1'b1;
            end else if (w_pop && !w_acc_rd) begin
                r_credits <= r_credits + 1'b1;
            end
        end
    end

    // In-flight read tracker. Clearing it on reset drops any read that was
    // still in flight, so it can never reach the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pipe_v <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                r_pipe_a[k] <= '0;
            end
        end else begin
            r_pipe_v[0] <= r_rd_en;
            r_pipe_a[0] <= r_rd_addr;
            for (int k = 1; k < RD_LAT; k++) begin
                r_pipe_v[k] <= r_pipe_v[k-1];
                r_pipe_a[k] <= r_pipe_a[k-1];
            end
        end
    end

    // Response FIFO control. Because RSP_DEPTH is a power of two, the
    // pointers wrap without any extra logic. The credit scheme guarantees
    // that a push never finds the FIFO full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage needs no reset: an entry is read only after it has been written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {r_pipe_a[RD_LAT-1], rd_data};
        end
    end

`ifdef KNN_HOST_CMD_STATS_EN
    logic [15:0] r_wr_count;
    logic [15:0] r_rd_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_count <= '0;
            r_rd_count <= '0;
        end else begin
            if (r_wr_en && (r_wr_count != 16'hFFFF)) r_wr_count <= r_wr_count + 1'b1;
            if (r_rd_en && (r_rd_count != 16'hFFFF)) r_rd_count <= r_rd_count + 1'b1;
        end
    end

    assign wr_count = r_wr_count;
    assign rd_count = r_rd_count;
`endif

endmodule

// File: tb/tb_knn_host_cmd.sv
module tb_knn_host_cmd;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 32;
  localparam int RD_LAT    = 2;
  localparam int RSP_DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr  = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [ADDR_W-1:0] rsp_addr;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;
`ifdef KNN_HOST_CMD_STATS_EN
  logic [15:0]       wr_count;
  logic [15:0]       rd_count;
`endif

  knn_host_cmd #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_addr(rsp_addr), .rsp_data(rsp_data), .busy(busy)
`ifdef KNN_HOST_CMD_STATS_EN
    , .wr_count(wr_count), .rd_count(rd_count)
`endif
  );

  // ---------------- responder: data valid RD_LAT(=2) cycles after rd_en ----------------
  function automatic logic [DATA_W-1:0] resp_of(input logic [ADDR_W-1:0] a);
    return (a == 8'h08) ? 32'hDEAD_BEEF : {24'hA5A5A5, a};
  endfunction

  logic [DATA_W-1:0] rsp_q0 = '0;
  logic [DATA_W-1:0] rsp_q1 = '0;
  always @(posedge clk) begin
    rsp_q0 <= rd_en ? resp_of(rd_addr) : '0;
    rsp_q1 <= rsp_q0;
  end
  assign rd_data = rsp_q1;

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // wait (bounded) for a response, compare it, then pop it
  task automatic pop_expect(input logic [ADDR_W-1:0] exp_addr);
    int n = 0;
    while (!rsp_valid && n < 12) begin
      tick();
      n++;
    end
    chk("rsp_valid_wait", rsp_valid, 1);
    chk("rsp_addr", rsp_addr, exp_addr);
    chk("rsp_data", rsp_data, resp_of(exp_addr));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  int acc;
  int seen;

  initial begin
    // ---- reset state ----
    repeat (3) tick();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    chk("rel_cmd_ready_low", cmd_ready, 0);
    tick();
    chk("rel_cmd_ready_high", cmd_ready, 1);

    // ---- single write ----
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h04; cmd_wdata = 32'h0000_0010;
    tick();
    cmd_valid = 1'b0;
    chk("wr_en_n1", wr_en, 1);
    chk("wr_addr_n1", wr_addr, 8'h04);
    chk("wr_data_n1", wr_data, 32'h10);
    chk("rd_en_n1", rd_en, 0);
    tick();
    chk("wr_en_n2", wr_en, 0);
    chk("wr_addr_hold", wr_addr, 8'h04);
    chk("wr_data_hold", wr_data, 32'h10);

    // ---- single read, response at acceptance+4 ----
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h08;
    tick();
    cmd_valid = 1'b0;
    chk("rd_en_n1", rd_en, 1);
    chk("rd_addr_n1", rd_addr, 8'h08);
    chk("busy_read", busy, 1);
    tick();
    chk("rsp_valid_n2", rsp_valid, 0);
    chk("rd_en_n2", rd_en, 0);
    tick();
    chk("rsp_valid_n3", rsp_valid, 0);
    tick();
    chk("rsp_valid_n4", rsp_valid, 1);
    chk("rsp_addr_n4", rsp_addr, 8'h08);
    chk("rsp_data_n4", rsp_data, 32'hDEAD_BEEF);
    tick();
    chk("rsp_hold_valid", rsp_valid, 1);
    chk("rsp_hold_data", rsp_data, 32'hDEAD_BEEF);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_popped", rsp_valid, 0);
    chk("busy_idle", busy, 0);

    // ---- backpressure: 4 credits, then stall ----
    acc = 0;
    cmd_write = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cmd_valid = 1'b1;
      cmd_addr  = 8'h10 + 8'(acc);
      if (cmd_ready) acc++;
      tick();
    end
    cmd_addr = 8'h10 + 8'(acc);
    chk("bp_accepted", acc, 4);
    chk("bp_ready_low", cmd_ready, 0);
    repeat (3) tick();
    chk("bp_ready_still_low", cmd_ready, 0);
    chk("bp_head_addr", rsp_addr, 8'h10);
    chk("bp_head_data", rsp_data, resp_of(8'h10));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      if (cmd_ready) acc++;
      tick();
    end
    cmd_valid = 1'b0;
    chk("bp_one_more", acc, 1);
    pop_expect(8'h11);
    pop_expect(8'h12);
    pop_expect(8'h13);
    pop_expect(8'h14);
    tick();
    chk("bp_busy_done", busy, 0);

    // ---- mixed stream W00 R01 W02 R03 ----
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h00; cmd_wdata = 32'h1111_0000;
    tick();
    chk("mix0_wr_en", wr_en, 1);
    chk("mix0_wr_addr", wr_addr, 8'h00);
    cmd_write = 1'b0; cmd_addr = 8'h01;
    tick();
    chk("mix1_rd_en", rd_en, 1);
    chk("mix1_wr_en", wr_en, 0);
    chk("mix1_rd_addr", rd_addr, 8'h01);
    cmd_write = 1'b1; cmd_addr = 8'h02; cmd_wdata = 32'h2222_0002;
    tick();
    chk("mix2_wr_en", wr_en, 1);
    chk("mix2_rd_en", rd_en, 0);
    chk("mix2_wr_data", wr_data, 32'h2222_0002);
    cmd_write = 1'b0; cmd_addr = 8'h03;
    tick();
    cmd_valid = 1'b0;
    chk("mix3_rd_en", rd_en, 1);
    chk("mix3_rd_addr", rd_addr, 8'h03);
    pop_expect(8'h01);
    pop_expect(8'h03);

    // ---- reset mid-read ----
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h20;
    tick();
    cmd_valid = 1'b0;
    chk("mr_rd_en", rd_en, 1);
    tick();
    rst = 1'b0;
    #1;
    chk("mr_busy_in_rst", busy, 0);
    chk("mr_ready_in_rst", cmd_ready, 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid) seen++;
      tick();
    end
    chk("mr_no_stale_rsp", seen, 0);
    chk("mr_busy", busy, 0);
    acc = 0;
    for (int i = 0; i < 7; i++) begin
      cmd_valid = 1'b1;
      cmd_addr  = 8'h30 + 8'(acc);
      if (cmd_ready) acc++;
      tick();
    end
    cmd_valid = 1'b0;
    chk("mr_full_credits", acc, 4);
    pop_expect(8'h30);
    pop_expect(8'h31);
    pop_expect(8'h32);
    pop_expect(8'h33);

`ifdef KNN_HOST_CMD_STATS_EN
    // ---- counters after the mid-read reset: no writes, four reads ----
    tick();
    chk("st_wr_count", wr_count, 16'd0);
    chk("st_rd_count", rd_count, 16'd4);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h40; cmd_wdata = 32'h0;
    for (int i = 0; i < 65540; i++) tick();
    cmd_valid = 1'b0;
    repeat (2) tick();
    chk("st_wr_sat", wr_count, 16'hFFFF);
    chk("st_rd_keep", rd_count, 16'd4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
